// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the 1024x8 text RAM between scanout, a host port and a clear-screen fill engine.
// Ports:
//   clk_i, reset_i (sync, active-low)
//   hpos_i/vpos_i      beam position; hpos_i[2:0]==DISP_SLOT reserves the cycle for the display fetch
//   disp_char_o        character code of the current cell, valid 2 clocks after its fetch slot
//   host_*             valid/ready request port; reads return on host_rdata_o with a host_rvalid_o pulse
//   clear_start_i, fill_byte_i, clear_busy_o, clear_done_o   whole-RAM fill engine
//   ram_addr_o/ram_din_o/ram_we_o/ram_dout_i                 RAM_sync interface (one-cycle read latency)
module text_ram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int DISP_SLOT = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [9:0]        hpos_i,
    input  logic [9:0]        vpos_i,
    output logic [DATA_W-1:0] disp_char_o,
    input  logic              host_valid_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ready_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o,
    input  logic              clear_start_i,
    input  logic [DATA_W-1:0] fill_byte_i,
    output logic              clear_busy_o,
    output logic              clear_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_dout_i
);
    typedef enum logic {IDLE, FILL} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              done_d;
    logic              disp_pend_q, rd_pend_q;
    logic [DATA_W-1:0] disp_char_q, host_rdata_q;
    logic              host_rvalid_q, clear_done_q;
    logic              disp_slot, fill_we;
    logic              unused_pos;
    // Only 32x32 cells are addressable; higher beam bits alias.
    assign unused_pos = ^{hpos_i[9:8], vpos_i[9:8], vpos_i[2:0]};
    always_comb begin
        disp_slot    = hpos_i[2:0] == DISP_SLOT[2:0];
        fill_we      = reset_i && state_q == FILL && !disp_slot;
        host_ready_o = reset_i && host_valid_i && state_q == IDLE && !clear_start_i && !disp_slot;
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        done_d       = 1'b0;
        if (state_q == IDLE && clear_start_i) begin
            state_d = FILL;
            cnt_d   = '0;
            fill_d  = fill_byte_i;
        end
        // The write at the all-ones address is the last one; no wrap-around pass.
        if (fill_we) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        ram_addr_o = disp_slot ? ADDR_W'({vpos_i[7:3], hpos_i[7:3]})
                   : state_q == FILL ? cnt_q : host_addr_i;
        ram_din_o  = state_q == FILL ? fill_q : host_wdata_i;
        ram_we_o   = fill_we || (host_ready_o && host_we_i);
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            fill_q        <= '0;
            disp_pend_q   <= 1'b0;
            rd_pend_q     <= 1'b0;
            disp_char_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            clear_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_q        <= fill_d;
            clear_done_q  <= done_d;
            // RAM data for a request appears the cycle after it; these flags mark whose data that is.
            disp_pend_q   <= disp_slot;
            rd_pend_q     <= host_ready_o && !host_we_i;
            host_rvalid_q <= rd_pend_q;
            if (disp_pend_q) disp_char_q <= ram_dout_i;
            if (rd_pend_q) host_rdata_q <= ram_dout_i;
        end
    end
    assign disp_char_o   = disp_char_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_rvalid_o = host_rvalid_q;
    assign clear_busy_o  = state_q == FILL;
    assign clear_done_o  = clear_done_q;
endmodule
